// File: rtl/immgen_pipe_pkg.sv
// Shared immediate-format codes and widths for the pipelined immediate generator.
// Also reused by the control decoder to select immtype.
package immgen_pipe_pkg;

  localparam int IMMTYPE_W = 4;

  typedef enum logic [IMMTYPE_W-1:0] {
    IMM_I   = 4'b0000,
    IMM_S   = 4'b0001,
    IMM_B   = 4'b0010,
    IMM_U   = 4'b0011,
    IMM_J   = 4'b0100,
    IMM_Z   = 4'b0101,
    IMM_SH  = 4'b0110,
    IMM_CI  = 4'b1000,
    IMM_CJ  = 4'b1001,
    IMM_CB  = 4'b1010,
    IMM_CIW = 4'b1011
  } immtype_e;

endpackage

// File: rtl/immgen_pipe_if.sv
// Request/result handshake bundle between decode, the immediate generator and execute.
// The master side issues instructions and consumes immediates; the slave side is immgen_pipe.
interface immgen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) ();
  import immgen_pipe_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          inst;
  logic [IMMTYPE_W-1:0] immtype;
  logic [TAG_W-1:0]     in_tag;

  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      imm;
  logic [TAG_W-1:0]     out_tag;
  logic                 illegal;

  modport master (
    output in_valid, inst, immtype, in_tag, out_ready,
    input  in_ready, out_valid, imm, out_tag, illegal
  );

  modport slave (
    input  in_valid, inst, immtype, in_tag, out_ready,
    output in_ready, out_valid, imm, out_tag, illegal
  );

endinterface

// File: rtl/immgen_pipe_skid.sv
// Generic 2-entry skid buffer: registered in_ready, output held stable under backpressure.
// Occupancy: main | skid | meaning -> 0|0 empty, 1|0 one beat, 1|1 full (in_ready low).
module immgen_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid;
  logic         skid_valid;
  logic         in_ready_q;
  logic [W-1:0] main_data;
  logic [W-1:0] skid_data;
  logic         in_fire;
  logic         main_free;

  assign in_fire   = in_valid & in_ready_q;
  assign main_free = ~main_valid | out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (main_free) begin
      // in_ready is low whenever skid is full, so skid refill and input accept never collide
      if (skid_valid) begin
        main_data  <= skid_data;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
        in_ready_q <= 1'b1;
      end else begin
        main_valid <= in_fire;
        if (in_fire) main_data <= in_data;
      end
    end else if (in_fire) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
      in_ready_q <= 1'b0;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign out_data  = main_data;

endmodule

// File: rtl/immgen_pipe.sv
// Pipelined immediate generator: combinational format mux into a 2-entry skid buffer.
// Define IMMGEN_RVC_EN to add the compressed CI/CJ/CB/CIW formats; otherwise those codes are illegal.
module immgen_pipe
  import immgen_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input logic          clk,
  input logic          rst_n,
  immgen_pipe_if.slave bus
);

  localparam int PW = XLEN + TAG_W + 1;

  logic [31:0]     inst;
  logic [63:0]     ext;
  logic            bad;
  logic [PW-1:0]   pay_in;
  logic [PW-1:0]   pay_out;

  assign inst = bus.inst;

  // Build every format at 64 bits, then keep the low XLEN bits
  always_comb begin
    ext = '0;
    bad = 1'b0;
    case (bus.immtype)
      IMM_I:  ext = {{52{inst[31]}}, inst[31:20]};
      IMM_S:  ext = {{52{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:  ext = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:  ext = {{32{inst[31]}}, inst[31:12], 12'b0};
      IMM_J:  ext = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_Z:  ext = {59'b0, inst[19:15]};
      IMM_SH: begin
        if (XLEN == 64) ext = {58'b0, inst[25:20]};
        else            ext = {59'b0, inst[24:20]};
      end
`ifdef IMMGEN_RVC_EN
      IMM_CI:  ext = {{58{inst[12]}}, inst[12], inst[6:2]};
      IMM_CJ:  ext = {{52{inst[12]}}, inst[12], inst[8], inst[10:9], inst[6], inst[7],
                      inst[2], inst[11], inst[5:3], 1'b0};
      IMM_CB:  ext = {{55{inst[12]}}, inst[12], inst[6:5], inst[2], inst[11:10], inst[4:3], 1'b0};
      IMM_CIW: ext = {54'b0, inst[10:7], inst[12:11], inst[5], inst[6], 2'b00};
`endif
      default: begin
        ext = '0;
        bad = 1'b1;
      end
    endcase
  end

`ifdef IMMGEN_RVC_EN
  logic unused_bits;
  assign unused_bits = ^{inst[1:0], ext[63:XLEN-1]};
`else
  logic unused_bits;
  assign unused_bits = ^{inst[6:0], ext[63:XLEN-1]};
`endif

  assign pay_in = {bad, ext[XLEN-1:0], bus.in_tag};

  immgen_skid #(.W(PW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (pay_in),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (pay_out)
  );

  assign bus.illegal = pay_out[PW-1];
  assign bus.imm     = pay_out[PW-2 -: XLEN];
  assign bus.out_tag = pay_out[TAG_W-1:0];

endmodule
